instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
Instruction fetch queue (IFQ) feeding the dispatch unit.
- Generates sequential PCs, requests instruction words from instruction memory over a req/ack handshake, and buffers {pc, icode} pairs in a circular FIFO.
- The dispatch side consumes the head entry with dpch_rd.
- A dispatch jump request (dpch_jmp) flushes the queue and redirects fetch to dpch_jmp_br_addr.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, minimum 2.
RESET_PC, 32'h00400000, fetch PC after reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
imem_req  output  1  fetch request; held high until imem_ack.
imem_addr  output  32  fetch address; stable while imem_req=1.
imem_ack  input  1  memory response valid; may arrive in the same cycle as imem_req.
imem_rdata  input  32  instruction word; valid when imem_ack=1.
ifq_pc  output  32  PC of the head entry.
ifq_icode  output  32  instruction of the head entry.
ifq_empty  output  1  no valid head entry.
dpch_rd  input  1  pop the head entry.
dpch_jmp  input  1  flush and redirect.
dpch_jmp_br_addr  input  32  redirect target; sampled when dpch_jmp=1.

Behaviour:
Reset:
- FIFO count=0, pointers=0, ifq_empty=1, ifq_pc=0, ifq_icode=0.
- fetch_pc=RESET_PC, FSM=IDLE, imem_req=0, imem_addr=RESET_PC.

Head output:
- Show-ahead: ifq_pc and ifq_icode reflect the head entry combinationally.
- Both read 0 when empty.

Pop:
- dpch_rd=1 with ifq_empty=0 removes the head at the clock edge.
- dpch_rd while empty is ignored; no underflow.

Push:
- Only from an accepted, non-discarded response; entry = {req_addr, imem_rdata}.
- Push and pop in the same cycle are both honoured; count is unchanged.

Pointers:
- log2(DEPTH)-bit pointers, modulo wrap.
- count is log2(DEPTH)+1 bits.

FSM states:
- IDLE: imem_req=0. If count<DEPTH (space counts the pop this cycle), latch req_addr=fetch_pc and go to REQ.
- REQ: imem_req=1, imem_addr=req_addr. On imem_ack, push and set fetch_pc=req_addr+4 (32-bit wraparound).
  - If space remains after this cycle's push/pop, latch the next req_addr and stay in REQ (back-to-back fetch).
  - Otherwise go to IDLE.
- DRAIN: imem_req=1 with the stale req_addr; the request cannot be retracted. On imem_ack, discard the data and go to IDLE.

Jump (dpch_jmp=1), highest priority:
- FIFO cleared: count=0, pointers=0.
- Any same-cycle pop or push is dropped.
- fetch_pc=dpch_jmp_br_addr.
- FSM transitions:
  - REQ without ack goes to DRAIN.
  - REQ with same-cycle ack discards the data and goes to IDLE.
  - DRAIN without ack stays in DRAIN; fetch_pc is still updated.
  - IDLE stays in IDLE.
- The first fetch from the new target is issued no earlier than the next cycle.

Full:
- At count=DEPTH, no request is issued.
- At most one request is ever outstanding, so no overflow is possible.

Reset mid-operation:
- Returns to reset state immediately; any outstanding memory response afterwards is ignored.
- The memory side must tolerate request withdrawal on reset.

Latency:
- Without bypass, a response at cycle N is visible at the head at N+1.
- Redirect to first valid head: 2 cycles minimum with a same-cycle ack.

Optional Feature:
IFQ_BYPASS_EN
- Defined: when the FIFO is empty and a valid, non-discarded imem_ack arrives, the response is presented combinationally that cycle: ifq_empty=0, ifq_pc=req_addr, ifq_icode=imem_rdata.
  - If dpch_rd=1 in that cycle, the entry is consumed and never written.
  - Otherwise it is pushed normally.
  - Bypass is suppressed when dpch_jmp=1.
- Undefined: no bypass; a response is visible at the head one cycle after ack.

Test Plan:
- Reset, memory acks every request in the same cycle, dpch_rd=0 -> addresses 0x00400000, 0x00400004, ... fetched; exactly DEPTH=8 entries; imem_req=0 when full; head pc=0x00400000.
- Full queue, dpch_rd=1 for one cycle -> head becomes 0x00400004; one new request issued at 0x00400020; count returns to 8.
- Jump with dpch_jmp=1, target 0x00400100, while in REQ with ack delayed 3 cycles -> FIFO empty next cycle; stale ack discarded; next imem_addr=0x00400100; first head pc=0x00400100.
- dpch_jmp coincident with dpch_rd and imem_ack -> no push; count=0; fetch_pc=target; FSM in IDLE.
- Empty queue, dpch_rd held high -> no state change; ifq_empty stays 1; ifq_pc=0.
- With IFQ_BYPASS_EN, empty queue, ack with rdata=0x00000013 and dpch_rd=1 in the same cycle -> ifq_empty=0 that cycle; ifq_icode=0x00000013; count stays 0 next cycle.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: generates sequential PCs, fetches instruction
// words over a req/ack handshake and buffers {pc, icode} pairs in a
// circular FIFO whose head is presented show-ahead to dispatch.
// A dispatch jump flushes the queue and redirects fetch.
// Optional build macro IFQ_BYPASS_EN: when the queue is empty, an accepted
// response is presented at the head in the same cycle it arrives.
module instr_fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifq_pc,
  output logic [31:0] ifq_icode,
  output logic        ifq_empty,
  input  logic        dpch_rd,
  input  logic        dpch_jmp,
  input  logic [31:0] dpch_jmp_br_addr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LP_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LP_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DRAIN
  } state_t;

  state_t      r_state;
  logic        r_imem_req;
  logic [31:0] r_req_addr;
  logic [31:0] r_fetch_pc;

  logic [31:0] r_pc_mem [DEPTH];
  logic [31:0] r_ic_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic        w_ack_ok;
  logic        w_pop;
  logic        w_push;
  logic        w_byp_vld;
  logic        w_byp_take;
  logic        w_empty_q;
  logic [AW:0] w_count_nxt;

  assign imem_req  = r_imem_req;
  assign imem_addr = r_req_addr;

  // Push/pop qualification and next occupancy; a jump suppresses both
  always_comb begin
    w_empty_q = (r_count == '0);
    w_ack_ok  = (r_state == ST_REQ) && imem_ack && !dpch_jmp;
    w_pop     = dpch_rd && !w_empty_q && !dpch_jmp;
`ifdef IFQ_BYPASS_EN
    w_byp_vld  = w_empty_q && w_ack_ok;
    w_byp_take = w_byp_vld && dpch_rd;
`else
    w_byp_vld  = 1'b0;
    w_byp_take = 1'b0;
`endif
    // A bypassed response consumed in its arrival cycle is never written
    w_push = w_ack_ok && !w_byp_take;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + LP_CNT_ONE;
      2'b01:   w_count_nxt = r_count - LP_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Show-ahead head presentation, zero when nothing is valid
  always_comb begin
    ifq_empty = w_empty_q && !w_byp_vld;
    ifq_pc    = '0;
    ifq_icode = '0;
    if (w_byp_vld) begin
      ifq_pc    = r_req_addr;
      ifq_icode = imem_rdata;
    end else if (!w_empty_q) begin
      ifq_pc    = r_pc_mem[r_rd_ptr];
      ifq_icode = r_ic_mem[r_rd_ptr];
    end
  end

  // Entry storage; no reset needed since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_pc_mem[r_wr_ptr] <= r_req_addr;
      r_ic_mem[r_wr_ptr] <= imem_rdata;
    end
  end

  // Pointer and occupancy tracking; reset and jump both empty the queue
  always_ff @(posedge clk) begin
    if (rst || dpch_jmp) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      r_count <= w_count_nxt;
    end
  end

  // Fetch FSM with registered request; a jump pending on an issued request drains it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_imem_req <= 1'b0;
      r_req_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else if (dpch_jmp) begin
      r_fetch_pc <= dpch_jmp_br_addr;
      unique case (r_state)
        ST_REQ, ST_DRAIN: begin
          if (imem_ack) begin
            r_state    <= ST_IDLE;
            r_imem_req <= 1'b0;
          end else begin
            r_state    <= ST_DRAIN;
            r_imem_req <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if ((r_count < LP_FULL) || w_pop) begin
            r_req_addr <= r_fetch_pc;
            r_state    <= ST_REQ;
            r_imem_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (imem_ack) begin
            r_fetch_pc <= r_req_addr + 32'd4;
            if (w_count_nxt < LP_FULL) begin
              r_req_addr <= r_req_addr + 32'd4;
            end else begin
              r_state    <= ST_IDLE;
              r_imem_req <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            r_state    <= ST_IDLE;
            r_imem_req <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: fill, pop/refill, jump during a
// pending request, jump with same-cycle pop and ack, empty pops, same-cycle
// response on an empty queue, and 32-bit PC wraparound.
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ifq_pc;
  logic [31:0] ifq_icode;
  logic        ifq_empty;
  logic        dpch_rd;
  logic        dpch_jmp;
  logic [31:0] dpch_jmp_br_addr;

  logic        ack_en;
  int unsigned n_acks;
  int unsigned n_checks;
  int unsigned n_fails;

  localparam logic [31:0] IMEM_KEY = 32'h5A5A_0000;

  instr_fetch_queue #(
    .DEPTH    (8),
    .RESET_PC (32'h0040_0000)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .ifq_pc           (ifq_pc),
    .ifq_icode        (ifq_icode),
    .ifq_empty        (ifq_empty),
    .dpch_rd          (dpch_rd),
    .dpch_jmp         (dpch_jmp),
    .dpch_jmp_br_addr (dpch_jmp_br_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: answers in the request cycle when enabled; word derived from address
  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = imem_addr ^ IMEM_KEY;

  always @(posedge clk) begin
    if (!rst && imem_req && imem_ack) n_acks = n_acks + 1;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ IMEM_KEY;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fails = n_fails + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    n_acks   = 0;
    rst = 1'b1;
    ack_en = 1'b1;
    dpch_rd = 1'b0;
    dpch_jmp = 1'b0;
    dpch_jmp_br_addr = '0;
    repeat (2) cyc();

    // Reset state
    check_eq("rst_req",   32'(imem_req), 32'd0);
    check_eq("rst_addr",  imem_addr, 32'h0040_0000);
    check_eq("rst_empty", 32'(ifq_empty), 32'd1);
    check_eq("rst_pc",    ifq_pc, 32'd0);
    check_eq("rst_icode", ifq_icode, 32'd0);

    // Fill with same-cycle acks
    rst = 1'b0;
    cyc();
    check_eq("first_req",  32'(imem_req), 32'd1);
    check_eq("first_addr", imem_addr, 32'h0040_0000);
    cyc();
    check_eq("second_addr", imem_addr, 32'h0040_0004);
    check_eq("first_head",  ifq_pc, 32'h0040_0000);
    repeat (15) cyc();
    check_eq("full_acks",  n_acks, 32'd8);
    check_eq("full_req",   32'(imem_req), 32'd0);
    check_eq("full_empty", 32'(ifq_empty), 32'd0);
    check_eq("full_pc",    ifq_pc, 32'h0040_0000);
    check_eq("full_icode", ifq_icode, word_of(32'h0040_0000));

    // One pop on a full queue refills one entry
    dpch_rd = 1'b1;
    cyc();
    dpch_rd = 1'b0;
    #1;
    check_eq("pop_head",     ifq_pc, 32'h0040_0004);
    check_eq("refill_req",   32'(imem_req), 32'd1);
    check_eq("refill_addr",  imem_addr, 32'h0040_0020);
    cyc();
    check_eq("refill_done",  32'(imem_req), 32'd0);
    check_eq("refill_acks",  n_acks, 32'd9);

    // Jump while a request waits on a delayed ack
    ack_en = 1'b0;
    dpch_rd = 1'b1;
    cyc();
    dpch_rd = 1'b0;
    #1;
    check_eq("pend_addr", imem_addr, 32'h0040_0024);
    dpch_jmp = 1'b1;
    dpch_jmp_br_addr = 32'h0040_0100;
    cyc();
    dpch_jmp = 1'b0;
    #1;
    check_eq("jmp_empty",      32'(ifq_empty), 32'd1);
    check_eq("drain_req",      32'(imem_req), 32'd1);
    check_eq("drain_addr",     imem_addr, 32'h0040_0024);
    cyc();
    cyc();
    ack_en = 1'b1;
    cyc();
    check_eq("stale_discard",  32'(ifq_empty), 32'd1);
    check_eq("drain_idle",     32'(imem_req), 32'd0);
    cyc();
    check_eq("redir_addr",     imem_addr, 32'h0040_0100);
    check_eq("redir_req",      32'(imem_req), 32'd1);
    cyc();
    check_eq("redir_head",     ifq_pc, 32'h0040_0100);
    check_eq("redir_icode",    ifq_icode, word_of(32'h0040_0100));
    check_eq("redir_next",     imem_addr, 32'h0040_0104);

    // Jump coincident with pop and ack
    dpch_rd = 1'b1;
    dpch_jmp = 1'b1;
    dpch_jmp_br_addr = 32'h0040_0200;
    cyc();
    dpch_rd = 1'b0;
    dpch_jmp = 1'b0;
    #1;
    check_eq("jra_empty", 32'(ifq_empty), 32'd1);
    check_eq("jra_idle",  32'(imem_req), 32'd0);
    cyc();
    check_eq("jra_addr",  imem_addr, 32'h0040_0200);

    // Reset mid-operation, then pops on an empty queue
    ack_en = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    dpch_rd = 1'b1;
    repeat (3) cyc();
    check_eq("erd_empty", 32'(ifq_empty), 32'd1);
    check_eq("erd_pc",    ifq_pc, 32'd0);
    check_eq("erd_icode", ifq_icode, 32'd0);
    check_eq("erd_addr",  imem_addr, 32'h0040_0000);

    // Response arriving on an empty queue with a same-cycle pop
    ack_en = 1'b1;
    #1;
`ifdef IFQ_BYPASS_EN
    check_eq("byp_empty", 32'(ifq_empty), 32'd0);
    check_eq("byp_pc",    ifq_pc, 32'h0040_0000);
    check_eq("byp_icode", ifq_icode, word_of(32'h0040_0000));
    cyc();
    ack_en = 1'b0;
    dpch_rd = 1'b0;
    #1;
    check_eq("byp_consumed", 32'(ifq_empty), 32'd1);
`else
    check_eq("nobyp_empty", 32'(ifq_empty), 32'd1);
    cyc();
    ack_en = 1'b0;
    dpch_rd = 1'b0;
    #1;
    check_eq("nobyp_pushed", 32'(ifq_empty), 32'd0);
    check_eq("nobyp_pc",     ifq_pc, 32'h0040_0000);
`endif
    check_eq("post_addr", imem_addr, 32'h0040_0004);

    // PC wraparound past the top of the address space
    dpch_jmp = 1'b1;
    dpch_jmp_br_addr = 32'hFFFF_FFFC;
    cyc();
    dpch_jmp = 1'b0;
    ack_en = 1'b1;
    cyc();
    cyc();
    check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    cyc();
    check_eq("wrap_addr1", imem_addr, 32'h0000_0000);
    check_eq("wrap_head",  ifq_pc, 32'hFFFF_FFFC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
